// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered instruction decode with valid/ready on both
// sides. Prefix words (opcode PREFIX_OP) accumulate upper immediate payloads
// that are concatenated onto the following instruction's immediate.
// Optional feature macro: INSTR_DEC_SIGNEXT_EN (sign-extend the merged
// immediate from its MSB; zero-extend when undefined).
module instr_decode_stage #(
  parameter int unsigned INSN_W   = 8,
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned REG_W    = 2,
  parameter logic [OPCODE_W-1:0] PREFIX_OP = '1,
  parameter int unsigned MAX_PFX  = 2,
  parameter logic [2**OPCODE_W-1:0] ILLEGAL_MASK = '0,
  localparam int unsigned IMM_W     = INSN_W - OPCODE_W,
  localparam int unsigned IMM_OUT_W = IMM_W * (MAX_PFX + 1),
  localparam int unsigned CNT_W     = $clog2(MAX_PFX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [INSN_W-1:0]    in_insn,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [REG_W-1:0]     out_rs,
  output logic [REG_W-1:0]     out_rt,
  output logic [REG_W-1:0]     out_rd,
  output logic [IMM_OUT_W-1:0] out_imm,
  output logic [CNT_W-1:0]     out_pfx_cnt,
  output logic                 out_illegal
);

  localparam int unsigned EXT_W = IMM_W * MAX_PFX;

  typedef enum logic {IDLE, PFX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     pfx_cnt_q, pfx_cnt_d;
  logic [EXT_W-1:0]     ext_q, ext_d;

  logic                 out_valid_q, out_valid_d;
  logic [OPCODE_W-1:0]  opcode_q, opcode_d;
  logic [REG_W-1:0]     rs_q, rs_d;
  logic [REG_W-1:0]     rt_q, rt_d;
  logic [IMM_OUT_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]     ocnt_q, ocnt_d;
  logic                 illegal_q, illegal_d;

  logic [OPCODE_W-1:0]  in_opcode;
  logic [REG_W-1:0]     in_rs, in_rt;
  logic [IMM_W-1:0]     in_imm;
  logic                 accept, is_pfx, overflow;
  logic [IMM_OUT_W-1:0] raw_imm, ext_imm;

  assign in_opcode = in_insn[INSN_W-1 -: OPCODE_W];
  assign in_rs     = in_insn[INSN_W-OPCODE_W-1 -: REG_W];
  assign in_rt     = in_insn[REG_W-1:0];
  assign in_imm    = in_insn[IMM_W-1:0];

  assign in_ready = (!out_valid_q || out_ready) && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign is_pfx   = (in_opcode == PREFIX_OP);
  assign overflow = is_pfx && (pfx_cnt_q == CNT_W'(MAX_PFX));

  // Merge accumulated payloads with the imm field and extend to output width.
  // Unused upper payload slots of ext_q are always zero, so {ext_q, imm} is
  // already the zero-extended value; sign extension shifts the real MSB to
  // the top and arithmetic-shifts it back down.
  always_comb begin
    logic [IMM_OUT_W-1:0] raw_sh;
    int unsigned          shamt;
    raw_imm = {ext_q, in_imm};
    shamt   = (MAX_PFX - int'(pfx_cnt_q)) * IMM_W;
    raw_sh  = raw_imm << shamt;
`ifdef INSTR_DEC_SIGNEXT_EN
    ext_imm = $unsigned($signed(raw_sh) >>> shamt);
`else
    ext_imm = raw_sh >> shamt;
`endif
  end

  // Next-state: prefix accumulation, bundle emission, flush and pop.
  always_comb begin
    state_d     = state_q;
    pfx_cnt_d   = pfx_cnt_q;
    ext_d       = ext_q;
    out_valid_d = out_valid_q && !out_ready;
    opcode_d    = opcode_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    ocnt_d      = ocnt_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d     = IDLE;
      pfx_cnt_d   = '0;
      ext_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (is_pfx && !overflow) begin
        ext_d     = (ext_q << IMM_W) | EXT_W'(in_imm);
        pfx_cnt_d = pfx_cnt_q + CNT_W'(1);
        state_d   = PFX;
      end else begin
        out_valid_d = 1'b1;
        rs_d        = in_rs;
        rt_d        = in_rt;
        ocnt_d      = pfx_cnt_q;
        if (overflow) begin
          opcode_d  = PREFIX_OP;
          imm_d     = '0;
          illegal_d = 1'b1;
        end else begin
          opcode_d  = in_opcode;
          imm_d     = ext_imm;
          illegal_d = ILLEGAL_MASK[in_opcode];
        end
        state_d   = IDLE;
        pfx_cnt_d = '0;
        ext_d     = '0;
      end
    end
  end

  // State and output bundle registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pfx_cnt_q   <= '0;
      ext_q       <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      ocnt_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pfx_cnt_q   <= pfx_cnt_d;
      ext_q       <= ext_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      ocnt_q      <= ocnt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = opcode_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_rd      = rs_q;
  assign out_imm     = imm_q;
  assign out_pfx_cnt = ocnt_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed testbench for instr_decode_stage (default geometry, opcode E
// marked illegal). Expected immediates depend on INSTR_DEC_SIGNEXT_EN.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [7:0]  in_insn;
  logic        in_ready, out_valid, out_illegal;
  logic [3:0]  out_opcode;
  logic [1:0]  out_rs, out_rt, out_rd, out_pfx_cnt;
  logic [11:0] out_imm;

  int errors = 0;
  int checks = 0;

`ifdef INSTR_DEC_SIGNEXT_EN
  localparam logic [11:0] EXP_3B = 12'hFFB;
  localparam logic [11:0] EXP_83 = 12'hF83;
`else
  localparam logic [11:0] EXP_3B = 12'h00B;
  localparam logic [11:0] EXP_83 = 12'h083;
`endif

  instr_decode_stage #(.ILLEGAL_MASK(16'h4000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_insn(in_insn), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_pfx_cnt(out_pfx_cnt), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    in_insn  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic [3:0] op, input logic [1:0] rs,
                            input logic [1:0] rt, input logic [11:0] imm,
                            input logic [1:0] cnt, input logic ill);
    chk({tag, ".valid"}, 16'(out_valid), 16'd1);
    chk({tag, ".opcode"}, 16'(out_opcode), 16'(op));
    chk({tag, ".rs"}, 16'(out_rs), 16'(rs));
    chk({tag, ".rt"}, 16'(out_rt), 16'(rt));
    chk({tag, ".rd"}, 16'(out_rd), 16'(rs));
    chk({tag, ".imm"}, 16'(out_imm), 16'(imm));
    chk({tag, ".pfx_cnt"}, 16'(out_pfx_cnt), 16'(cnt));
    chk({tag, ".illegal"}, 16'(out_illegal), 16'(ill));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_insn = 8'h00;
    tick();
    // reset state
    chk("rst.valid", 16'(out_valid), 16'd0);
    chk("rst.opcode", 16'(out_opcode), 16'd0);
    chk("rst.imm", 16'(out_imm), 16'd0);
    chk("rst.pfx_cnt", 16'(out_pfx_cnt), 16'd0);
    chk("rst.illegal", 16'(out_illegal), 16'd0);
    chk("rst.in_ready", 16'(in_ready), 16'd0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready", 16'(in_ready), 16'd1);

    // single word
    push(8'h3B);
    chk_bundle("single", 4'h3, 2'd2, 2'd3, EXP_3B, 2'd0, 1'b0);
    tick();
    chk("single.drain", 16'(out_valid), 16'd0);

    // prefix merge
    push(8'hF1);
    chk("merge.pfx1", 16'(out_valid), 16'd0);
    push(8'hF2);
    chk("merge.pfx2", 16'(out_valid), 16'd0);
    push(8'h25);
    chk_bundle("merge", 4'h2, 2'd1, 2'd1, 12'h125, 2'd2, 1'b0);

    // prefix overflow then an unprefixed word
    push(8'hF1);
    push(8'hF2);
    push(8'hF3);
    chk_bundle("ovf", 4'hF, 2'd0, 2'd3, 12'h000, 2'd2, 1'b1);
    push(8'h14);
    chk_bundle("post_ovf", 4'h1, 2'd1, 2'd0, 12'h004, 2'd0, 1'b0);
    tick();

    // single prefix with sign bit set in the payload
    push(8'hF8);
    push(8'h03);
    chk_bundle("sext", 4'h0, 2'd0, 2'd3, EXP_83, 2'd1, 1'b0);
    tick();

    // backpressure
    out_ready = 1'b0;
    push(8'h3B);
    in_insn = 8'h47; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 16'(in_ready), 16'd0);
      chk("bp.valid", 16'(out_valid), 16'd1);
      chk("bp.opcode", 16'(out_opcode), 16'd3);
      chk("bp.imm", 16'(out_imm), 16'(EXP_3B));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    chk_bundle("bp.next", 4'h4, 2'd1, 2'd3, 12'h007, 2'd0, 1'b0);
    tick();
    chk("bp.drain", 16'(out_valid), 16'd0);

    // flush after a prefix
    push(8'hF7);
    flush = 1'b1; in_insn = 8'h12; in_valid = 1'b1;
    #1;
    chk("flush.in_ready", 16'(in_ready), 16'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.valid", 16'(out_valid), 16'd0);
    push(8'h12);
    chk_bundle("flush.after", 4'h1, 2'd0, 2'd2, 12'h002, 2'd0, 1'b0);
    tick();

    // flush drops a held bundle
    out_ready = 1'b0;
    push(8'h3B);
    chk("flushhold.valid", 16'(out_valid), 16'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("flushhold.dropped", 16'(out_valid), 16'd0);

    // reset mid prefix run
    push(8'hF5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstpfx.valid", 16'(out_valid), 16'd0);
    push(8'h12);
    chk_bundle("rstpfx", 4'h1, 2'd0, 2'd2, 12'h002, 2'd0, 1'b0);

    // illegal mask
    push(8'hE0);
    chk_bundle("ill.E", 4'hE, 2'd0, 2'd0, 12'h000, 2'd0, 1'b1);
    push(8'hD0);
    chk_bundle("ill.D", 4'hD, 2'd0, 2'd0, 12'h000, 2'd0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
